// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing defaults, counter widths and pixel field layout
package vga_timing_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int PIX_W        = 24;
    localparam int CNT_W        = 10;
    localparam int DIV_W        = 4;
    localparam int R_MSB        = 23;
    localparam int R_LSB        = 16;
    localparam int G_MSB        = 15;
    localparam int G_LSB        = 8;
    localparam int B_MSB        = 7;
    localparam int B_LSB        = 0;
endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: pixel-tick divider plus h/v position counters and raw timing decode
// Ports: clk, rst (async active-low); pix_tick, h_cnt, v_cnt, active, hsync_n, vsync_n,
//        frame_start_n -- all combinational from the counter state.
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_tick,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             frame_start_n
);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] HA       = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] VA       = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS0      = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS1      = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS0      = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS1      = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;

    assign pix_tick      = div_cnt == DIV_LAST;
    assign active        = (h_cnt < HA) && (v_cnt < VA);
    assign hsync_n       = !((h_cnt >= HS0) && (h_cnt < HS1));
    assign vsync_n       = !((v_cnt >= VS0) && (v_cnt < VS1));
    assign frame_start_n = !(pix_tick && h_cnt == '0 && v_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= pix_tick ? '0 : div_cnt + DIV_W'(1);
            if (pix_tick) begin
                h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + CNT_W'(1);
                if (h_cnt == H_LAST)
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/vga_pixel_out.sv
// vga_pixel_out: drains the FWFT pixel FIFO into registered VGA RGB/sync/blank outputs
// Ports: clk, rst (async active-low); fifo_data/fifo_empty in, fifo_read out (pop pulse);
//        red/green/blue, hsync, vsync, blank, frame_start registered; underflow sticky.
module vga_pixel_out
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_read,
    output logic [7:0]       red,
    output logic [7:0]       green,
    output logic [7:0]       blue,
    output logic             hsync,
    output logic             vsync,
    output logic             blank,
    output logic             frame_start,
    output logic             underflow
);
    logic             pix_tick;
    logic             active;
    logic             hsync_n;
    logic             vsync_n;
    logic             frame_start_n;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             unused_pos;

    vga_sync_counter #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_sync (
        .clk(clk), .rst(rst), .pix_tick(pix_tick), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .active(active), .hsync_n(hsync_n), .vsync_n(vsync_n), .frame_start_n(frame_start_n)
    );

    // position counters are only of interest for probing; the decode above covers this stage
    assign unused_pos = ^{h_cnt, v_cnt};

    // pop on the same edge that the RGB register captures the head word
    assign fifo_read = pix_tick && active && !fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank       <= 1'b1;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            frame_start <= !frame_start_n;
            if (pix_tick) begin
                red   <= fifo_read ? fifo_data[R_MSB:R_LSB] : '0;
                green <= fifo_read ? fifo_data[G_MSB:G_LSB] : '0;
                blue  <= fifo_read ? fifo_data[B_MSB:B_LSB] : '0;
                hsync <= hsync_n;
                vsync <= vsync_n;
                blank <= !active;
            end
            if (pix_tick && active && fifo_empty)
                underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_pixel_out.sv
// tb_vga_pixel_out: directed checks of vga_pixel_out on a shrunken 15x8 raster, CLK_DIV=4
module tb_vga_pixel_out;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b0;
    logic        inc = 1'b0;
    logic [23:0] cnt = 24'd1;
    logic [23:0] fifo_data;
    logic        fifo_read;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        frame_start;
    logic        underflow;

    int checks = 0;
    int errors = 0;
    int t = 0;
    int e = 0;
    int cyc = 0, fs_t = 0, fs_prev = 0, hf_t = 0, hf_prev = 0, hr_t = 0, vf_t = 0, vr_t = 0;
    int line_rd = 0, line_reads = 0, frame_rd = 0, frame_reads = 0, rd_empty = 0, rd_rst = 0;
    logic hs_q = 1'b1;
    logic vs_q = 1'b1;

    assign fifo_data = inc ? cnt : 24'hFF0000;

    vga_pixel_out #(
        .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_read(fifo_read), .red(red), .green(green), .blue(blue), .hsync(hsync),
        .vsync(vsync), .blank(blank), .frame_start(frame_start), .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_read) cnt <= cnt + 24'd1;
        if (fifo_read && fifo_empty) rd_empty <= rd_empty + 1;
        if (fifo_read && !rst) rd_rst <= rd_rst + 1;
        hs_q <= hsync;
        vs_q <= vsync;
        if (hs_q && !hsync) begin
            hf_prev    <= hf_t;
            hf_t       <= cyc;
            line_reads <= line_rd;
            line_rd    <= fifo_read ? 1 : 0;
        end else
            line_rd <= line_rd + (fifo_read ? 1 : 0);
        if (!hs_q && hsync) hr_t <= cyc;
        if (vs_q && !vsync) vf_t <= cyc;
        if (!vs_q && vsync) vr_t <= cyc;
        if (frame_start) begin
            fs_prev     <= fs_t;
            fs_t        <= cyc;
            frame_reads <= frame_rd;
            frame_rd    <= fifo_read ? 1 : 0;
        end else
            frame_rd <= frame_rd + (fifo_read ? 1 : 0);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // k = posedges since the last reset release; samples 1 time unit after that edge
    task automatic at(input int k);
        repeat (k - t) @(posedge clk);
        t = k;
        #1;
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_red", int'(red), 0);
        chk("rst_green", int'(green), 0);
        chk("rst_blue", int'(blue), 0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_blank", int'(blank), 1);
        chk("rst_read", int'(fifo_read), 0);
        chk("rst_fs", int'(frame_start), 0);
        chk("rst_uf", int'(underflow), 0);
        rst = 1'b1;
        t = 0;
        at(2);
        chk("read_before_tick", int'(fifo_read), 0);
        at(3);
        chk("first_read", int'(fifo_read), 1);
        chk("blank_before_px0", int'(blank), 1);
        at(4);
        chk("px0_red", int'(red), 255);
        chk("px0_green", int'(green), 0);
        chk("px0_blank", int'(blank), 0);
        chk("px0_fs", int'(frame_start), 1);
        chk("px0_hsync", int'(hsync), 1);
        at(5);
        chk("fs_one_clk", int'(frame_start), 0);
        chk("read_one_clk", int'(fifo_read), 0);
        // empty across the horizontal blanking of line 0
        at(32);
        fifo_empty = 1'b1;
        at(37);
        chk("hblank_blank", int'(blank), 1);
        chk("hblank_red", int'(red), 0);
        at(60);
        chk("hblank_no_uf", int'(underflow), 0);
        chk("hblank_no_read", rd_empty, 0);
        chk("hsync_offset", hf_t - fs_t, 40);
        chk("hsync_width", hr_t - hf_t, 12);
        fifo_empty = 1'b0;
        // empty for pixels 2..4 of line 1
        at(68);
        fifo_empty = 1'b1;
        at(72);
        chk("uf_rgb", int'({red, green, blue}), 0);
        chk("uf_blank", int'(blank), 0);
        chk("uf_set", int'(underflow), 1);
        at(80);
        chk("uf_px4_red", int'(red), 0);
        fifo_empty = 1'b0;
        at(84);
        chk("uf_px5_red", int'(red), 255);
        at(106);
        chk("line1_reads", line_reads, 5);
        chk("line_period", hf_t - hf_prev, 60);
        chk("uf_no_read", rd_empty, 0);
        at(484);
        chk("frame1_fs", int'(frame_start), 1);
        chk("frame1_red", int'(red), 255);
        at(486);
        chk("frame_period", fs_t - fs_prev, 480);
        chk("frame_reads", frame_reads, 29);
        chk("vsync_offset", vf_t - fs_prev, 300);
        chk("vsync_width", vr_t - vf_t, 120);
        chk("uf_sticky", int'(underflow), 1);
        // incrementing stream with random empties: every shown pixel is the next word
        at(488);
        inc = 1'b1;
        e = int'(cnt);
        for (int i = 0; i < 120; i++) begin
            at(492 + 4 * i);
            if (!blank && {red, green, blue} != 24'd0) begin
                chk("seq_pixel", int'({red, green, blue}), e);
                e++;
            end
            fifo_empty = ($urandom_range(0, 3) == 0);
        end
        chk("seq_all_shown", int'(cnt), e);
        chk("seq_no_empty_read", rd_empty, 0);
        fifo_empty = 1'b0;
        inc = 1'b0;
        // asynchronous reset in the middle of an active line
        at(977);
        chk("pre_rst_red", int'(red), 255);
        rst = 1'b0;
        #1;
        chk("arst_red", int'(red), 0);
        chk("arst_blank", int'(blank), 1);
        chk("arst_hsync", int'(hsync), 1);
        chk("arst_vsync", int'(vsync), 1);
        chk("arst_uf", int'(underflow), 0);
        chk("arst_read", int'(fifo_read), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold_read", int'(fifo_read), 0);
        chk("arst_hold_fs", int'(frame_start), 0);
        rst = 1'b1;
        t = 0;
        at(3);
        chk("rel_first_read", int'(fifo_read), 1);
        chk("no_read_in_rst", rd_rst, 0);
        at(4);
        chk("rel_fs", int'(frame_start), 1);
        chk("rel_red", int'(red), 255);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_pixel_out.md
# vga_pixel_out

Downstream stage of `display_plane`. Drains the 24-bit pixel FIFO that `display_plane` fills. Generates 640x480@60 VGA timing from a divided pixel tick and drives registered RGB, hsync, vsync and blank to the DAC/pins. Reports FIFO underflow so the fill path can be checked in simulation and on hardware.

## Interface
Parameters:
- CLK_DIV, 4 — system clocks per pixel; 100 MHz gives a 25 MHz pixel rate; legal values 1..16.
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48 — horizontal timing, in pixels.
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33 — vertical timing, in lines.

Ports:
- clk  in  1  system clock, the same clock as `display_plane`.
- rst  in  1  asynchronous, active-low reset.
- fifo_data  in  24  head-of-FIFO pixel {R[23:16],G[15:8],B[7:0]}. The FIFO is first-word-fall-through: fifo_data is valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO holds no pixel.
- fifo_read  out  1  pops the head word. Single-cycle pulse.
- red, green, blue  out  8 each  pixel colour. Registered.
- hsync, vsync  out  1 each  active-low sync. Registered.
- blank  out  1  1 outside the active area. Registered.
- frame_start  out  1  1-clk pulse at the tick of h=0, v=0.
- underflow  out  1  sticky. Set when an active pixel finds the FIFO empty.

## Operation
- The divider counter div_cnt runs 0..CLK_DIV-1. pix_tick=1 when div_cnt==CLK_DIV-1.
- h_cnt counts 0..H_TOTAL-1 (800) on pix_tick. At wrap it returns to 0 and v_cnt advances.
- v_cnt counts 0..V_TOTAL-1 (525) and wraps to 0.
- Region order per line is active, front porch, sync, back porch. Frames use the same order.
- active = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
- hsync=0 for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vsync=0 for the same region computed on v_cnt.
- On a pix_tick with active and !fifo_empty:
  - fifo_read=1 for that clk.
  - RGB register loads fifo_data.
- On a pix_tick with active and fifo_empty:
  - fifo_read stays 0.
  - RGB loads 0.
  - underflow is set to 1.
- On a pix_tick with !active: RGB loads 0 and blank=1. The FIFO is never read outside the active area.
- underflow stays set until reset.
- fifo_read is asserted only on a pix_tick clk, so it is at most one pulse per pixel.
- Reset values:
  - div_cnt=0, h_cnt=0, v_cnt=0.
  - red/green/blue=0, hsync=1, vsync=1, blank=1.
  - fifo_read=0, frame_start=0, underflow=0.
- Reset asserted mid-frame: all state returns to the reset values immediately, asynchronously. After release, timing restarts at h=0, v=0 with the first pix_tick CLK_DIV clks later. No FIFO read occurs while rst=0.

## Timing
- fifo_read is combinational from pix_tick, active and fifo_empty. It is high in the same clk as the tick.
- The FIFO pops on that clk's edge, and the RGB register captures fifo_data on the same edge.
- All visible outputs (RGB, hsync, vsync, blank, frame_start) are registered. They change 1 clk after the tick that computed them and hold for CLK_DIV clks.
- hsync, vsync and blank are registered in the same stage as RGB, so all outputs stay aligned.
- Pixel (0,0) appears on the outputs 1 clk after the first pix_tick following reset release, i.e. at clk CLK_DIV+1 after release.
- Line period is 800·CLK_DIV clks. Frame period is 420000·CLK_DIV clks.
- Simultaneous events:
  - fifo_empty dropping on the same clk as a pix_tick: the pixel is read on that clk, because the empty flag is sampled in that cycle.
  - Line wrap and frame wrap on the same tick: v_cnt goes from 524 to 0 and frame_start pulses.
- Arithmetic: div_cnt is 4 bits; h_cnt and v_cnt are 10 bits. Region bounds are constant sums evaluated at elaboration. Comparisons are unsigned.

## Structure
- Package vga_timing_pkg holds:
  - the 640x480 default constants;
  - localparams H_TOTAL=800 and V_TOTAL=525;
  - pixel width 24;
  - the RGB field slice positions.
- Sub-module vga_sync_counter holds the divider and the h/v counters. Its outputs are pix_tick, h_cnt, v_cnt, active, hsync_n, vsync_n and frame_start_n, all unregistered.
- The top level vga_pixel_out holds the FIFO read logic, the output register stage and the underflow flag.

## Test plan
- Reset release with CLK_DIV=4 and the FIFO always non-empty holding 0xFF0000:
  - first fifo_read at clk 4;
  - red=0xFF and blank=0 at clk 5;
  - exactly 640 fifo_read pulses per line and 307200 per frame.
- Sync placement:
  - hsync falls 656 ticks after h=0 and stays low 96 ticks;
  - vsync is low for lines 490-491;
  - the frame_start period is 1680000 clks.
- fifo_empty=1 for 3 ticks mid-line at h=100:
  - RGB=0 for those 3 pixels;
  - underflow=1 and it stays 1;
  - no fifo_read during those ticks;
  - the line still ends at h=799.
- fifo_empty=1 throughout blanking: underflow stays 0 and fifo_read stays 0.
- Incrementing pattern from a FIFO model fed by `display_plane`+ROM with fifo_full toggling: the output pixel sequence equals the ROM address sequence with no skips and no duplicates.
- rst asserted at h=300, v=200 for 2 clks:
  - outputs go to reset values immediately;
  - after release, frame_start pulses CLK_DIV+1 clks later;
  - no fifo_read occurs while rst=0.
